// File: rtl/store.sv
// store: write-back engine that copies a run of 512-byte blocks of one mounted
// drive image from disk RAM into a local buffer and then out to the SD card.
module store #(
  parameter int BLOCKS     = 1600,
  parameter int DISK_WORDS = 204800
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_req,
  input  logic [1:0]  wr_drive,
  input  logic [10:0] wr_blk,
  input  logic [10:0] wr_count,
  input  logic [3:0]  mounted,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] sector_sd,
  output logic [3:0]  write_sd,
  input  logic        strobe,
  input  logic [8:0]  index,
  output logic [7:0]  outbyte,
  input  logic        busy_sd,
  input  logic        done_sd,
  output logic [19:0] dsk_addr,
  input  logic [31:0] dsk_din,
  output logic        dsk_read,
  input  logic        dsk_busy,
  input  logic        dsk_asck
);

  localparam logic [10:0] BLOCKS_W = 11'(BLOCKS);

  typedef enum logic [2:0] {
    IDLE, FILL_REQ, FILL_WAIT, FILL_ACK, SD_REQ, SD_WAIT, SD_DONE
  } state_t;

  state_t      state, state_d;
  logic [1:0]  drive;
  logic [10:0] blk;
  logic [10:0] remaining;
  logic [6:0]  idx;
  logic        err_latched;
  logic [31:0] blk_buf [128];

  logic        req_bad, req_empty, req_clamp;
  logic [10:0] avail;
  logic [31:0] rd_word;

  // Classify an incoming request: rejected, empty, or clamped at the image end.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    avail     = BLOCKS_W - wr_blk;
    req_bad   = !mounted[wr_drive] || (wr_blk >= BLOCKS_W);
    req_empty = (wr_count == 11'd0);
    req_clamp = (wr_count > avail);
  end

  // Word address inside the selected drive image; the sum never exceeds 20 bits.
  assign dsk_addr = 20'(drive) * 20'(DISK_WORDS) + {2'b00, blk, idx};

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (wr_req && !req_bad && !req_empty) state_d = FILL_REQ;
      FILL_REQ:  state_d = FILL_WAIT;
      FILL_WAIT: if (dsk_busy) state_d = FILL_ACK;
      FILL_ACK:  if (dsk_asck) state_d = (idx == 7'd127) ? SD_REQ : FILL_REQ;
      SD_REQ:    state_d = SD_WAIT;
      SD_WAIT:   if (busy_sd) state_d = SD_DONE;
      SD_DONE:   if (done_sd) state_d = (remaining == 11'd1) ? IDLE : FILL_REQ;
      default:   state_d = IDLE;
    endcase
  end

  // Request latching, block/word counters and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      dsk_read    <= 1'b0;
      write_sd    <= 4'd0;
      sector_sd   <= 32'd0;
      drive       <= 2'd0;
      blk         <= 11'd0;
      remaining   <= 11'd0;
      idx         <= 7'd0;
      err_latched <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_req) begin
            if (req_bad) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else if (req_empty) begin
              done <= 1'b1;
            end else begin
              drive       <= wr_drive;
              blk         <= wr_blk;
              remaining   <= req_clamp ? avail : wr_count;
              err_latched <= req_clamp;
              idx         <= 7'd0;
              busy        <= 1'b1;
            end
          end
        end
        FILL_REQ: dsk_read <= 1'b1;
        FILL_ACK: begin
          if (dsk_asck) begin
            dsk_read <= 1'b0;
            idx      <= idx + 7'd1;  // wraps to 0 after word 127
          end
        end
        SD_REQ: begin
          sector_sd <= {21'd0, blk};
          write_sd  <= 4'b0001 << drive;
        end
        SD_WAIT: if (busy_sd) write_sd <= 4'd0;
        SD_DONE: begin
          if (done_sd) begin
            remaining <= remaining - 11'd1;
            if (remaining == 11'd1) begin
              done <= 1'b1;
              err  <= err_latched;
              busy <= 1'b0;
            end else begin
              blk <= blk + 11'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Sector buffer fill from disk RAM.
  always_ff @(posedge clk) begin
    // NOTE: buffer contents are don't-care after reset, so the array has no reset and may map to block RAM.
    if (state == FILL_ACK && dsk_asck) blk_buf[idx] <= dsk_din;
  end

  assign rd_word = blk_buf[index[8:2]];

  // Byte server: one-cycle latency, little-endian byte select, active in every state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    outbyte <= 8'd0;
    else if (strobe) outbyte <= rd_word[8*index[1:0] +: 8];
  end

endmodule
